prng_hist_monitor: RTL and testbench
====================================

// Module: prng_hist_monitor
// PURPOSE
//  In-hardware consumer and checker for the PRNG random_out stream. Decodes each 16-bit
//  Q4.11 sample to one of 10 levels (0, 1/9 .. 9/9). Accumulates a per-level histogram
//  over a fixed window, then drains the counts through a valid/ready read port.
//  Sits downstream of PRNG in the Level-1 pipeline, for on-chip distribution checks.
// PARAMETERS
//  DATA_W     16    sample width (Q4.11)
//  NUM_LEVELS 10    number of legal levels
//  CNT_W      16    width of each level counter and of invalid_cnt
//  WINDOW     1024  samples accepted per capture window (>=1)
// PORTS
//  clk          in   1           clock; all logic on posedge
//  rst          in   1           synchronous, active-low reset (rst==0 resets)
//  start        in   1           begin new window; honoured only in IDLE
//  sample_in    in   DATA_W      PRNG random_out
//  sample_valid in   1           sample_in valid this cycle
//  busy         out  1           1 in ACCUM or DRAIN
//  done         out  1           1-cycle pulse after the final read handshake
//  rd_valid     out  1           histogram entry available
//  rd_ready     in   1           consumer accepts entry
//  rd_index     out  4           level index 0..NUM_LEVELS-1
//  rd_count     out  CNT_W       count for rd_index
//  rd_last      out  1           rd_index==NUM_LEVELS-1 while rd_valid
//  invalid_cnt  out  CNT_W       samples matching no level in the last/current window
// BEHAVIOUR
//  Reset: state=IDLE; all counts, invalid_cnt, sample counter, rd_index=0; busy/done/rd_valid=0.
//  Levels: 0000,00E3,01C7,02AA,038E,0471,0555,0638,071C,0800 hex; exact match only.
//  FSM IDLE: start=1 -> clear counts, invalid_cnt, sample counter; next state ACCUM.
//    Samples are ignored in IDLE.
//  FSM ACCUM: each sample_valid cycle increments count[idx] on a hit, else invalid_cnt.
//    Either way the sample counter increments; the result is visible the next cycle.
//    The sample that brings the sample counter to WINDOW moves the FSM to DRAIN.
//    rd_valid=1 from the following cycle.
//  FSM DRAIN: rd_valid=1; rd_index/rd_count held stable until rd_valid&&rd_ready, then rd_index++.
//    The handshake with rd_last=1 moves the FSM to IDLE and pulses done on the next cycle.
//    Samples are ignored in DRAIN.
//  Counters saturate at 2^CNT_W-1, with no wrap. The sample counter is sized for WINDOW.
//  Ignored inputs: start is ignored while busy; rd_ready is ignored when rd_valid=0.
//  Post-window hold: counts and invalid_cnt hold after a window until the next start.
//  Reset mid-operation: any state -> IDLE with all state cleared; a partial window is discarded.
// CONFIGURATION
//  PRNG_HIST_MAXRUN_EN defined: adds output max_run[CNT_W-1:0].
//    max_run = longest run of consecutive valid samples decoding to the same level within the window.
//    It is cleared on start, saturates, and an invalid sample breaks the run.
//  PRNG_HIST_MAXRUN_EN undefined: the port and its logic are absent; all else identical.
// STRUCTURE
//  Shared package prng_pkg: LEVEL_0..LEVEL_9 constants, NUM_LEVELS, IDLE/ACCUM/DRAIN encoding.
//  Sub-module prng_level_decoder: combinational sample -> {hit, idx[3:0]} against the prng_pkg table.
// TESTING
//  1 Reset: rst=0 for 2 cycles -> busy=0, rd_valid=0, done=0, invalid_cnt=0, all counts 0.
//  2 WINDOW=16: start, then 16x 0x0555 -> DRAIN gives idx6=16, others 0; rd_last at idx9; one done pulse.
//  3 WINDOW=16: 8x 0x0001 interleaved with 8x 0x0800 -> idx9=8, invalid_cnt=8.
//  4 Drain with rd_ready=0 for 5 cycles at idx3 -> rd_index/rd_count stable, no skipped index.
//    Also: start during DRAIN is ignored.
//  5 CNT_W=4, WINDOW=32, all 0x0000 -> idx0=15 (saturated). Rst=0 after 7 ACCUM samples -> IDLE, all 0.
//  6 PRNG seed=5'b01001 driving sample_in, WINDOW=1024 -> sum(counts)+invalid_cnt=1024.
//    With PRNG_HIST_MAXRUN_EN: 0x00E3 x3, 0x0000, 0x00E3 x5 -> max_run=5.

Source files
------------

// File: rtl/prng_pkg.sv
// Shared level table and FSM encoding for the PRNG histogram monitor.
package prng_pkg;

    localparam int NUM_LEVELS = 10;

    // Q4.11 encodings of 0, 1/9 .. 9/9
    localparam logic [15:0] LEVEL_0 = 16'h0000;
    localparam logic [15:0] LEVEL_1 = 16'h00E3;
    localparam logic [15:0] LEVEL_2 = 16'h01C7;
    localparam logic [15:0] LEVEL_3 = 16'h02AA;
    localparam logic [15:0] LEVEL_4 = 16'h038E;
    localparam logic [15:0] LEVEL_5 = 16'h0471;
    localparam logic [15:0] LEVEL_6 = 16'h0555;
    localparam logic [15:0] LEVEL_7 = 16'h0638;
    localparam logic [15:0] LEVEL_8 = 16'h071C;
    localparam logic [15:0] LEVEL_9 = 16'h0800;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic logic [15:0] level_value(input int i);
        case (i)
            0:       return LEVEL_0;
            1:       return LEVEL_1;
            2:       return LEVEL_2;
            3:       return LEVEL_3;
            4:       return LEVEL_4;
            5:       return LEVEL_5;
            6:       return LEVEL_6;
            7:       return LEVEL_7;
            8:       return LEVEL_8;
            default: return LEVEL_9;
        endcase
    endfunction

endpackage

// File: rtl/prng_level_decoder.sv
// Combinational exact-match decode of a Q4.11 sample to a level index.
module prng_level_decoder
    import prng_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] sample,
    output logic              hit,
    output logic [3:0]        idx
);

    // Levels are distinct, so at most one compare can match.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (sample == DATA_W'(level_value(i))) begin
                hit = 1'b1;
                idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/prng_hist_monitor.sv
// Windowed per-level histogram of the PRNG stream, drained over a valid/ready port.
// Optional feature macro: PRNG_HIST_MAXRUN_EN adds the max_run output.
//
// state | meaning
// IDLE  | waiting for start; counts held from the last window
// ACCUM | counting WINDOW valid samples into the histogram
// DRAIN | presenting one entry per level on the read port
module prng_hist_monitor
    import prng_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16,
    parameter int WINDOW = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              busy,
    output logic              done,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [3:0]        rd_index,
    output logic [CNT_W-1:0]  rd_count,
    output logic              rd_last,
    output logic [CNT_W-1:0]  invalid_cnt
`ifdef PRNG_HIST_MAXRUN_EN
    ,
    output logic [CNT_W-1:0]  max_run
`endif
);

    localparam int SMP_W = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   counts [NUM_LEVELS];
    logic [SMP_W-1:0]   smp_cnt;
    logic               dec_hit;
    logic [3:0]         dec_idx;
    logic               accept, win_end, rd_fire, last_fire, clear;

    prng_level_decoder #(.DATA_W(DATA_W)) u_dec (
        .sample (sample_in),
        .hit    (dec_hit),
        .idx    (dec_idx)
    );

    assign accept    = (state == ACCUM) && sample_valid;
    assign win_end   = accept && (smp_cnt == SMP_W'(WINDOW - 1));
    assign rd_fire   = rd_valid && rd_ready;
    assign last_fire = rd_fire && rd_last;
    assign clear     = (state == IDLE) && start;
    assign rd_count  = counts[rd_index];

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        rd_valid  = 1'b0;
        rd_last   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = ACCUM;
            end
            ACCUM: begin
                busy = 1'b1;
                if (win_end) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy     = 1'b1;
                rd_valid = 1'b1;
                rd_last  = (rd_index == 4'(NUM_LEVELS - 1));
                if (rd_fire && rd_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_LEVELS; i++) counts[i] <= '0;
            invalid_cnt <= '0;
            smp_cnt     <= '0;
            rd_index    <= '0;
            done        <= 1'b0;
        end else begin
            done <= last_fire;
            if (clear) begin
                for (int i = 0; i < NUM_LEVELS; i++) counts[i] <= '0;
                invalid_cnt <= '0;
                smp_cnt     <= '0;
                rd_index    <= '0;
            end
            if (accept) begin
                smp_cnt <= smp_cnt + SMP_W'(1);
                if (dec_hit) begin
                    if (counts[dec_idx] != CNT_MAX)
                        counts[dec_idx] <= counts[dec_idx] + CNT_W'(1);
                end else if (invalid_cnt != CNT_MAX) begin
                    invalid_cnt <= invalid_cnt + CNT_W'(1);
                end
            end
            // Index wraps to 0 after the last entry so the next drain starts clean.
            if (rd_fire) rd_index <= last_fire ? 4'd0 : rd_index + 4'd1;
        end
    end

`ifdef PRNG_HIST_MAXRUN_EN
    logic [CNT_W-1:0] cur_run, run_nxt;
    logic [3:0]       last_idx;
    logic             run_live;

    always_comb begin
        run_nxt = CNT_W'(1);
        if (run_live && (dec_idx == last_idx))
            run_nxt = (cur_run == CNT_MAX) ? cur_run : cur_run + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            cur_run  <= '0;
            last_idx <= '0;
            run_live <= 1'b0;
            max_run  <= '0;
        end else if (accept) begin
            if (dec_hit) begin
                cur_run  <= run_nxt;
                last_idx <= dec_idx;
                run_live <= 1'b1;
                if (run_nxt > max_run) max_run <= run_nxt;
            end else begin
                cur_run  <= '0;
                run_live <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_prng_hist_monitor.sv
// Directed bench for prng_hist_monitor: three instances (small window, 4-bit counters, full window).
module tb_prng_hist_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        sample_valid = 1'b0;
    logic        rd_ready = 1'b0;
    logic [15:0] sample_in = '0;
    int          sel = 0;

    always #5 clk = ~clk;

    logic        busy_a, done_a, rd_valid_a, rd_last_a;
    logic [3:0]  rd_index_a;
    logic [15:0] rd_count_a, invalid_cnt_a;
    logic        busy_b, done_b, rd_valid_b, rd_last_b;
    logic [3:0]  rd_index_b;
    logic [3:0]  rd_count_b, invalid_cnt_b;
    logic        busy_c, done_c, rd_valid_c, rd_last_c;
    logic [3:0]  rd_index_c;
    logic [15:0] rd_count_c, invalid_cnt_c;
`ifdef PRNG_HIST_MAXRUN_EN
    logic [15:0] max_run_a, max_run_c;
    logic [3:0]  max_run_b;
`endif

    prng_hist_monitor #(.DATA_W(16), .CNT_W(16), .WINDOW(16)) dut_a (
        .clk(clk), .rst(rst), .start(start && sel == 0), .sample_in(sample_in),
        .sample_valid(sample_valid && sel == 0), .busy(busy_a), .done(done_a),
        .rd_valid(rd_valid_a), .rd_ready(rd_ready && sel == 0), .rd_index(rd_index_a),
        .rd_count(rd_count_a), .rd_last(rd_last_a), .invalid_cnt(invalid_cnt_a)
`ifdef PRNG_HIST_MAXRUN_EN
        , .max_run(max_run_a)
`endif
    );

    prng_hist_monitor #(.DATA_W(16), .CNT_W(4), .WINDOW(32)) dut_b (
        .clk(clk), .rst(rst), .start(start && sel == 1), .sample_in(sample_in),
        .sample_valid(sample_valid && sel == 1), .busy(busy_b), .done(done_b),
        .rd_valid(rd_valid_b), .rd_ready(rd_ready && sel == 1), .rd_index(rd_index_b),
        .rd_count(rd_count_b), .rd_last(rd_last_b), .invalid_cnt(invalid_cnt_b)
`ifdef PRNG_HIST_MAXRUN_EN
        , .max_run(max_run_b)
`endif
    );

    prng_hist_monitor #(.DATA_W(16), .CNT_W(16), .WINDOW(1024)) dut_c (
        .clk(clk), .rst(rst), .start(start && sel == 2), .sample_in(sample_in),
        .sample_valid(sample_valid && sel == 2), .busy(busy_c), .done(done_c),
        .rd_valid(rd_valid_c), .rd_ready(rd_ready && sel == 2), .rd_index(rd_index_c),
        .rd_count(rd_count_c), .rd_last(rd_last_c), .invalid_cnt(invalid_cnt_c)
`ifdef PRNG_HIST_MAXRUN_EN
        , .max_run(max_run_c)
`endif
    );

    logic        busy, done, rd_valid, rd_last;
    logic [3:0]  rd_index;
    logic [15:0] rd_count, invalid_cnt;

    always_comb begin
        case (sel)
            0: begin
                busy = busy_a; done = done_a; rd_valid = rd_valid_a; rd_last = rd_last_a;
                rd_index = rd_index_a; rd_count = rd_count_a; invalid_cnt = invalid_cnt_a;
            end
            1: begin
                busy = busy_b; done = done_b; rd_valid = rd_valid_b; rd_last = rd_last_b;
                rd_index = rd_index_b; rd_count = {12'd0, rd_count_b};
                invalid_cnt = {12'd0, invalid_cnt_b};
            end
            default: begin
                busy = busy_c; done = done_c; rd_valid = rd_valid_c; rd_last = rd_last_c;
                rd_index = rd_index_c; rd_count = rd_count_c; invalid_cnt = invalid_cnt_c;
            end
        endcase
    end

    logic [15:0] lv [10] = '{16'h0000, 16'h00E3, 16'h01C7, 16'h02AA, 16'h038E,
                             16'h0471, 16'h0555, 16'h0638, 16'h071C, 16'h0800};
    int errors = 0;
    int checks = 0;
    int got_cnt [10];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] s);
        sample_in    = s;
        sample_valid = 1'b1;
        cycle();
        sample_valid = 1'b0;
    endtask

    task automatic begin_window();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic drain(input int k0);
        for (int k = k0; k < 10; k++) begin
            int budget = 0;
            while (!rd_valid && budget < 20) begin
                cycle();
                budget++;
            end
            check("drain rd_valid", rd_valid, 1);
            check("drain rd_index", rd_index, k);
            check("drain rd_last", rd_last, (k == 9) ? 1 : 0);
            got_cnt[k] = rd_count;
            rd_ready = 1'b1;
            cycle();
            rd_ready = 1'b0;
        end
        check("done pulse", done, 1);
        check("busy after drain", busy, 0);
        cycle();
        check("done one cycle", done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] lfsr;
        logic [15:0] s;
        int exp_cnt [10];
        int exp_inv;
        int sum;
        bit found;

        // 1: reset
        sel = 0;
        repeat (2) cycle();
        rst = 1'b1;
        check("rst busy", busy, 0);
        check("rst rd_valid", rd_valid, 0);
        check("rst done", done, 0);
        check("rst invalid_cnt", invalid_cnt, 0);
        check("rst rd_index", rd_index, 0);
        check("rst rd_count", rd_count, 0);
`ifdef PRNG_HIST_MAXRUN_EN
        check("rst max_run", max_run_a, 0);
`endif

        // 2: one level only, LEVEL_6
        begin_window();
        check("accum busy", busy, 1);
        for (int i = 0; i < 15; i++) send(16'h0555);
        check("no drain before window end", rd_valid, 0);
        send(16'h0555);
        check("drain after window", rd_valid, 1);
        check("t2 invalid_cnt", invalid_cnt, 0);
        drain(0);
        for (int j = 0; j < 10; j++) check("t2 count", got_cnt[j], (j == 6) ? 16 : 0);

        // 3: invalid interleaved with LEVEL_9, idle cycles not counted
        begin_window();
        for (int i = 0; i < 8; i++) begin
            send(16'h0001);
            sample_in = 16'h0800;
            cycle();
            send(16'h0800);
        end
        check("t3 invalid_cnt", invalid_cnt, 8);
        drain(0);
        check("t3 idx9", got_cnt[9], 8);
        check("t3 idx0", got_cnt[0], 0);
        send(16'h0001);
        send(16'h0800);
        check("idle samples ignored", invalid_cnt, 8);
        check("idle stays idle", busy, 0);

        // 4: back-pressure at idx3, start during DRAIN ignored
        begin_window();
        for (int i = 0; i < 16; i++) send(lv[i % 4]);
        for (int k = 0; k < 3; k++) begin
            check("t4 pre rd_index", rd_index, k);
            rd_ready = 1'b1;
            cycle();
            rd_ready = 1'b0;
        end
        for (int c = 0; c < 5; c++) begin
            check("stall rd_index", rd_index, 3);
            check("stall rd_count", rd_count, 4);
            start = (c == 2);
            cycle();
            start = 1'b0;
        end
        check("stall still draining", rd_valid, 1);
        drain(3);
        check("t4 idx3", got_cnt[3], 4);
        check("t4 idx4", got_cnt[4], 0);
        check("start in drain ignored", busy, 0);

`ifdef PRNG_HIST_MAXRUN_EN
        begin_window();
        for (int i = 0; i < 3; i++) send(16'h00E3);
        send(16'h0000);
        for (int i = 0; i < 5; i++) send(16'h00E3);
        send(16'h0001);
        for (int i = 0; i < 4; i++) send(16'h00E3);
        send(16'h0001);
        send(16'h0800);
        check("max_run", max_run_a, 5);
        drain(0);
        check("max_run idx1", got_cnt[1], 12);
`endif

        // 5: 4-bit counters saturate; mid-window reset discards
        sel = 1;
        begin_window();
        for (int i = 0; i < 32; i++) send(16'h0000);
        check("t5 drain", rd_valid, 1);
        drain(0);
        check("t5 saturated idx0", got_cnt[0], 15);
        check("t5 idx1", got_cnt[1], 0);
        begin_window();
        for (int i = 0; i < 7; i++) send(16'h0000);
        check("t5 partial count", rd_count, 7);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        check("mid rst busy", busy, 0);
        check("mid rst rd_count", rd_count, 0);
        check("mid rst rd_valid", rd_valid, 0);
        check("mid rst invalid", invalid_cnt, 0);

        // 6: pseudo-random stream over a full 1024 window
        sel = 2;
        lfsr = 16'h0009;
        exp_inv = 0;
        for (int j = 0; j < 10; j++) exp_cnt[j] = 0;
        begin_window();
        for (int n = 0; n < 1024; n++) begin
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            s = lfsr[0] ? lv[lfsr[7:4] % 10] : lfsr;
            found = 1'b0;
            for (int j = 0; j < 10; j++) begin
                if (s == lv[j]) begin
                    exp_cnt[j]++;
                    found = 1'b1;
                end
            end
            if (!found) exp_inv++;
            if (lfsr[1]) cycle();
            send(s);
        end
        check("t6 drain", rd_valid, 1);
        check("t6 invalid_cnt", invalid_cnt, exp_inv);
        drain(0);
        sum = 0;
        for (int j = 0; j < 10; j++) begin
            check("t6 count", got_cnt[j], exp_cnt[j]);
            sum += got_cnt[j];
        end
        check("t6 total", sum + invalid_cnt, 1024);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
